// File: rtl/pet_pkg.sv
// Shared encodings, widths and the saturating arithmetic helper for the pet need generator.
package pet_pkg;

    localparam int NEED_W      = 4;
    localparam int HAPPY_W     = 5;
    localparam int SAT_W       = HAPPY_W;
    localparam int NEED_THRESH = 12;

    localparam logic [2:0] CMD_FEED     = 3'd0;
    localparam logic [2:0] CMD_PLAY     = 3'd1;
    localparam logic [2:0] CMD_CLEAN    = 3'd2;
    localparam logic [2:0] CMD_SLEEP    = 3'd3;
    localparam logic [2:0] CMD_MEDICINE = 3'd4;
    localparam logic [2:0] CMD_PET      = 3'd5;

    typedef enum logic [1:0] {
        AWAKE  = 2'd0,
        ASLEEP = 2'd1,
        DEAD   = 2'd2
    } state_e;

    // clamp(cur + add - sub, 0, max), evaluated signed with headroom so no wrap can occur.
    function automatic logic [SAT_W-1:0] sat_add_sub(
        input logic [SAT_W-1:0] cur,
        input logic [SAT_W-1:0] add,
        input logic [SAT_W-1:0] sub,
        input logic [SAT_W-1:0] max
    );
        logic signed [SAT_W+1:0] sum;
        sum = $signed({2'b00, cur}) + $signed({2'b00, add}) - $signed({2'b00, sub});
        if (sum[SAT_W+1]) return '0;
        if (sum > $signed({2'b00, max})) return max;
        return sum[SAT_W-1:0];
    endfunction

endpackage

// File: rtl/pet_need_cnt.sv
// One need level with its decay period counter; the level rises by one each PER advancing ticks.
module pet_need_cnt
    import pet_pkg::*;
#(
    parameter int WIDTH = NEED_W,
    parameter int PER   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick_i,
    input  logic             hold_i,
    input  logic [WIDTH-1:0] inc_i,
    input  logic [WIDTH-1:0] dec_i,
    input  logic             clear_i,
    output logic [WIDTH-1:0] level_o,
    output logic [WIDTH-1:0] level_nxt_o
);

    localparam int                CW   = (PER > 1) ? $clog2(PER) : 1;
    localparam logic [CW-1:0]     LAST = CW'(PER - 1);
    localparam logic [SAT_W-1:0]  MAX  = SAT_W'((1 << WIDTH) - 1);

    logic [CW-1:0]    per_q, per_d;
    logic [WIDTH-1:0] level_q, level_d;
    logic             advance, wrap;

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        advance = tick_i && !hold_i;
        wrap    = advance && (per_q == LAST);
        per_d   = per_q;
        if (advance) per_d = wrap ? '0 : per_q + 1'b1;
        level_d = WIDTH'(sat_add_sub(SAT_W'(level_q), SAT_W'(inc_i) + SAT_W'(wrap), SAT_W'(dec_i), MAX));
        if (clear_i) level_d = '0;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            per_q   <= '0;
            level_q <= '0;
        end else begin
            per_q   <= per_d;
            level_q <= level_d;
        end
    end

    assign level_o     = level_q;
    assign level_nxt_o = level_d;

endmodule

// File: rtl/pet_needs.sv
// Need-level generator: game-tick divider, sleep/death FSM, command decode and health tracking.
module pet_needs
    import pet_pkg::*;
#(
    parameter int TICK_DIV    = 50_000_000,
    parameter int HUNGER_PER  = 4,
    parameter int HAPPY_PER   = 2,
    parameter int HYGIENE_PER = 6,
    parameter int ENERGY_PER  = 5,
    parameter int SOCIAL_PER  = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    input  logic [2:0]         cmd,
    output logic               cmd_ready,
    output logic [NEED_W-1:0]  hunger,
    output logic [HAPPY_W-1:0] happiness,
    output logic [NEED_W-1:0]  health,
    output logic [NEED_W-1:0]  hygiene,
    output logic [NEED_W-1:0]  energy,
    output logic [NEED_W-1:0]  social,
    output logic               asleep,
    output logic               alive,
    output logic               tick
);

    localparam int TW = $clog2(TICK_DIV);

    logic [TW-1:0]      div_q, div_d;
    state_e             state_q, state_d;
    logic [NEED_W-1:0]  health_q, health_d;
    logic               accept, live_tick, health_up;
    logic               is_feed, is_play, is_clean, is_sleep, is_medicine, is_pet;
    logic [NEED_W-1:0]  hunger_nxt, energy_nxt, hygiene_nxt, social_nxt;
    logic [HAPPY_W-1:0] happy_nxt;
    logic               unused_nxt;

    assign tick      = (div_q == TW'(TICK_DIV - 1));
    assign div_d     = tick ? '0 : div_q + 1'b1;
    assign cmd_ready = (state_q == AWAKE);
    assign asleep    = (state_q == ASLEEP);
    assign alive     = (state_q != DEAD);
    assign live_tick = tick && alive;
    assign accept    = cmd_valid && cmd_ready;

    assign is_feed     = accept && (cmd == CMD_FEED);
    assign is_play     = accept && (cmd == CMD_PLAY);
    assign is_clean    = accept && (cmd == CMD_CLEAN);
    assign is_sleep    = accept && (cmd == CMD_SLEEP);
    assign is_medicine = accept && (cmd == CMD_MEDICINE);
    assign is_pet      = accept && (cmd == CMD_PET);

    pet_need_cnt #(.WIDTH(NEED_W), .PER(HUNGER_PER)) u_hunger (
        .clk(clk), .rst_n(reset), .tick_i(live_tick), .hold_i(1'b0),
        .inc_i('0), .dec_i(is_feed ? 4'd4 : 4'd0), .clear_i(1'b0),
        .level_o(hunger), .level_nxt_o(hunger_nxt)
    );

    pet_need_cnt #(.WIDTH(HAPPY_W), .PER(HAPPY_PER)) u_happy (
        .clk(clk), .rst_n(reset), .tick_i(live_tick), .hold_i(1'b0),
        .inc_i('0), .dec_i(is_play ? 5'd6 : (is_pet ? 5'd1 : 5'd0)), .clear_i(1'b0),
        .level_o(happiness), .level_nxt_o(happy_nxt)
    );

    pet_need_cnt #(.WIDTH(NEED_W), .PER(HYGIENE_PER)) u_hygiene (
        .clk(clk), .rst_n(reset), .tick_i(live_tick), .hold_i(1'b0),
        .inc_i('0), .dec_i('0), .clear_i(is_clean),
        .level_o(hygiene), .level_nxt_o(hygiene_nxt)
    );

    // Sleep freezes energy decay and instead drains one unit per tick.
    pet_need_cnt #(.WIDTH(NEED_W), .PER(ENERGY_PER)) u_energy (
        .clk(clk), .rst_n(reset), .tick_i(live_tick), .hold_i(asleep),
        .inc_i(is_play ? 4'd2 : 4'd0), .dec_i((live_tick && asleep) ? 4'd1 : 4'd0), .clear_i(1'b0),
        .level_o(energy), .level_nxt_o(energy_nxt)
    );

    pet_need_cnt #(.WIDTH(NEED_W), .PER(SOCIAL_PER)) u_social (
        .clk(clk), .rst_n(reset), .tick_i(live_tick), .hold_i(1'b0),
        .inc_i('0), .dec_i(is_pet ? 4'd3 : 4'd0), .clear_i(1'b0),
        .level_o(social), .level_nxt_o(social_nxt)
    );

    // Only the hunger and energy look-ahead values steer the FSM.
    assign unused_nxt = ^{hygiene_nxt, social_nxt, happy_nxt};

    assign health_up = live_tick && ((hunger >= NEED_W'(NEED_THRESH)) || (hygiene >= NEED_W'(NEED_THRESH)));
    assign health_d  = NEED_W'(sat_add_sub(SAT_W'(health_q), SAT_W'(health_up),
                                           is_medicine ? SAT_W'(4) : SAT_W'(0), SAT_W'(15)));

    always_comb begin
        state_d = state_q;
        case (state_q)
            AWAKE:   if (is_sleep && (energy != '0)) state_d = ASLEEP;
            ASLEEP:  if (energy_nxt == '0) state_d = AWAKE;
            default: state_d = state_q;
        endcase
        if ((state_q != DEAD) && (hunger_nxt == '1)) state_d = DEAD;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q    <= '0;
            state_q  <= AWAKE;
            health_q <= '0;
        end else begin
            div_q    <= div_d;
            state_q  <= state_d;
            health_q <= health_d;
        end
    end

    assign health = health_q;

endmodule

// File: tb/tb_pet_needs.sv
// Scoreboarded bench for pet_needs: a tick-count reference model predicts every cycle's outputs.
module tb_pet_needs;
    import pet_pkg::*;

    localparam int TDIV  = 4;
    localparam int PER_H = 4;
    localparam int PER_P = 2;
    localparam int PER_Y = 6;
    localparam int PER_E = 5;
    localparam int PER_S = 3;
    localparam int M_AWAKE  = 0;
    localparam int M_ASLEEP = 1;
    localparam int M_DEAD   = 2;

    typedef struct packed {
        logic [3:0] hunger;
        logic [4:0] happy;
        logic [3:0] health;
        logic [3:0] hygiene;
        logic [3:0] energy;
        logic [3:0] social;
        logic       asleep;
        logic       alive;
        logic       ready;
        logic       tick;
    } obs_t;

    typedef struct {
        int hunger, happy, health, hygiene, energy, social;
        int st;
        int ticks, awake_ticks, cyc;
    } mdl_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic [2:0] cmd;

    logic       ready_a, asleep_a, alive_a, tick_a;
    logic [3:0] hunger_a, health_a, hygiene_a, energy_a, social_a;
    logic [4:0] happy_a;
    logic       ready_b, asleep_b, alive_b, tick_b;
    logic [3:0] hunger_b, health_b, hygiene_b, energy_b, social_b;
    logic [4:0] happy_b;
    obs_t       act_a, act_b;

    int   checks = 0;
    int   errors = 0;
    mdl_t ma, mb;
    obs_t exp_a[$];
    obs_t exp_b[$];

    always #5 clk = ~clk;

    pet_needs #(.TICK_DIV(TDIV), .HUNGER_PER(PER_H), .HAPPY_PER(PER_P), .HYGIENE_PER(PER_Y),
                .ENERGY_PER(PER_E), .SOCIAL_PER(PER_S)) u_dut_a (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd(cmd), .cmd_ready(ready_a),
        .hunger(hunger_a), .happiness(happy_a), .health(health_a), .hygiene(hygiene_a),
        .energy(energy_a), .social(social_a), .asleep(asleep_a), .alive(alive_a), .tick(tick_a)
    );

    pet_needs #(.TICK_DIV(TDIV), .HUNGER_PER(1), .HAPPY_PER(PER_P), .HYGIENE_PER(PER_Y),
                .ENERGY_PER(PER_E), .SOCIAL_PER(PER_S)) u_dut_b (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd(cmd), .cmd_ready(ready_b),
        .hunger(hunger_b), .happiness(happy_b), .health(health_b), .hygiene(hygiene_b),
        .energy(energy_b), .social(social_b), .asleep(asleep_b), .alive(alive_b), .tick(tick_b)
    );

    assign act_a = {hunger_a, happy_a, health_a, hygiene_a, energy_a, social_a, asleep_a, alive_a, ready_a, tick_a};
    assign act_b = {hunger_b, happy_b, health_b, hygiene_b, energy_b, social_b, asleep_b, alive_b, ready_b, tick_b};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int clampi(input int v, input int mx);
        return (v < 0) ? 0 : ((v > mx) ? mx : v);
    endfunction

    function automatic mdl_t mdl_reset();
        mdl_t m;
        m = '{default: 0};
        m.st = M_AWAKE;
        return m;
    endfunction

    // Advance one clock cycle from the behavioural rules: decay is a count of ticks modulo each period.
    function automatic mdl_t adv(input mdl_t m, input logic v, input logic [2:0] c, input int hper);
        mdl_t n;
        bit   tk, acc, clean;
        int   dh, dp, dy, de, ds, dl;
        n = m;
        tk = (m.cyc % TDIV) == TDIV - 1;
        acc = v && (m.st == M_AWAKE);
        clean = 0;
        dh = 0; dp = 0; dy = 0; de = 0; ds = 0; dl = 0;
        n.cyc = m.cyc + 1;
        if (m.st != M_DEAD) begin
            if (tk) begin
                n.ticks = m.ticks + 1;
                dh = (n.ticks % hper == 0) ? 1 : 0;
                dp = (n.ticks % PER_P == 0) ? 1 : 0;
                dy = (n.ticks % PER_Y == 0) ? 1 : 0;
                ds = (n.ticks % PER_S == 0) ? 1 : 0;
                if (m.st == M_AWAKE) begin
                    n.awake_ticks = m.awake_ticks + 1;
                    de = (n.awake_ticks % PER_E == 0) ? 1 : 0;
                end else begin
                    de = -1;
                end
                if (m.hunger >= 12 || m.hygiene >= 12) dl = 1;
            end
            if (acc) begin
                case (c)
                    CMD_FEED:     dh -= 4;
                    CMD_PLAY:     begin dp -= 6; de += 2; end
                    CMD_CLEAN:    clean = 1;
                    CMD_MEDICINE: dl -= 4;
                    CMD_PET:      begin ds -= 3; dp -= 1; end
                    default:      ;
                endcase
            end
            n.hunger  = clampi(m.hunger + dh, 15);
            n.happy   = clampi(m.happy + dp, 31);
            n.hygiene = clean ? 0 : clampi(m.hygiene + dy, 15);
            n.energy  = clampi(m.energy + de, 15);
            n.social  = clampi(m.social + ds, 15);
            n.health  = clampi(m.health + dl, 15);
            if (acc && c == CMD_SLEEP && m.energy != 0) n.st = M_ASLEEP;
            if (m.st == M_ASLEEP && n.energy == 0) n.st = M_AWAKE;
            if (n.hunger == 15) n.st = M_DEAD;
        end
        return n;
    endfunction

    function automatic obs_t obs_of(input mdl_t m);
        obs_t o;
        o.hunger  = 4'(m.hunger);
        o.happy   = 5'(m.happy);
        o.health  = 4'(m.health);
        o.hygiene = 4'(m.hygiene);
        o.energy  = 4'(m.energy);
        o.social  = 4'(m.social);
        o.asleep  = (m.st == M_ASLEEP);
        o.alive   = (m.st != M_DEAD);
        o.ready   = (m.st == M_AWAKE);
        o.tick    = (m.cyc % TDIV) == TDIV - 1;
        return o;
    endfunction

    // Called just after a rising edge: drive this cycle's inputs, queue its expected outputs, advance.
    task automatic step(input logic v, input logic [2:0] c);
        cmd_valid = v;
        cmd = c;
        exp_a.push_back(obs_of(ma));
        exp_b.push_back(obs_of(mb));
        @(posedge clk);
        #1;
        ma = adv(ma, v, c, PER_H);
        mb = adv(mb, v, c, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        obs_t r;
        r = obs_of(mdl_reset());
        check({tag, "_a"}, 32'(act_a), 32'(r));
        check({tag, "_b"}, 32'(act_b), 32'(r));
    endtask

    initial begin : monitor
        obs_t ea, eb;
        forever begin
            @(negedge clk);
            if (exp_a.size() > 0) begin
                ea = exp_a.pop_front();
                eb = exp_b.pop_front();
                check("mon_a", 32'(act_a), 32'(ea));
                check("mon_b", 32'(act_b), 32'(eb));
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int n, s0, h0, h1, e_exp;
        reset = 1'b0;
        cmd_valid = 1'b0;
        cmd = 3'd0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("por");
        reset = 1'b1;
        ma = mdl_reset();
        mb = mdl_reset();

        repeat (64) step(1'b0, 3'd0);
        check("idle_hunger", 32'(hunger_a), 32'd4);
        check("idle_happy", 32'(happy_a), 32'd8);
        check("idle_social", 32'(social_a), 32'd5);
        check("idle_hygiene", 32'(hygiene_a), 32'd2);
        check("idle_energy", 32'(energy_a), 32'd3);
        check("idle_health", 32'(health_a), 32'd0);
        check("dead_alive_b", 32'(alive_b), 32'd0);
        check("dead_hunger_b", 32'(hunger_b), 32'd15);

        repeat (16) step(1'b0, 3'd0);
        check("prefeed_hunger", 32'(hunger_a), 32'd5);
        step(1'b1, CMD_FEED);
        check("feed1_hunger", 32'(hunger_a), 32'd1);
        check("dead_frozen_b", 32'(hunger_b), 32'd15);
        step(1'b1, CMD_FEED);
        check("feed2_hunger", 32'(hunger_a), 32'd0);

        step(1'b1, CMD_SLEEP);
        check("sleep_asleep", 32'(asleep_a), 32'd1);
        check("sleep_ready", 32'(ready_a), 32'd0);
        n = 0;
        while (ma.st == M_ASLEEP && n < 40) begin
            step(1'b1, CMD_PLAY);
            n++;
        end
        check("wake_in_time", 32'(n < 40), 32'd1);
        check("wake_energy", 32'(energy_a), 32'd0);
        check("wake_asleep", 32'(asleep_a), 32'd0);
        check("wake_ready", 32'(ready_a), 32'd1);
        e_exp = 2 + (((ma.cyc % TDIV == TDIV - 1) && ((ma.awake_ticks + 1) % PER_E == 0)) ? 1 : 0);
        step(1'b1, CMD_PLAY);
        check("held_play_energy", 32'(energy_a), 32'(e_exp));

        n = 0;
        while (!((ma.cyc % TDIV == TDIV - 1) && ((ma.ticks + 1) % PER_S == 0)) && n < 64) begin
            step(1'b0, 3'd0);
            n++;
        end
        check("pet_wrap_found", 32'(n < 64), 32'd1);
        s0 = ma.social;
        step(1'b1, CMD_PET);
        check("pet_tick_social", 32'(social_a), 32'(clampi(s0 + 1 - 3, 15)));

        n = 0;
        while (ma.hygiene < 12 && n < 1000) begin
            step(n % 8 == 0, CMD_FEED);
            n++;
        end
        check("hygiene_reached", 32'(n < 1000), 32'd1);
        h0 = ma.health;
        repeat (12) step(1'b0, 3'd0);
        check("health_plus3", 32'(health_a), 32'(clampi(h0 + 3, 15)));
        if (ma.cyc % TDIV == TDIV - 1) step(1'b0, 3'd0);
        h1 = ma.health;
        step(1'b1, CMD_MEDICINE);
        check("medicine_health", 32'(health_a), 32'(clampi(h1 - 4, 15)));

        repeat (400) step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));

        @(negedge clk);
        #1;
        reset = 1'b0;
        #1;
        check_reset_outputs("async");
        @(posedge clk);
        #1;
        reset = 1'b1;
        ma = mdl_reset();
        mb = mdl_reset();
        repeat (200) step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pet_needs.md
# pet_needs

Need-level generator for the tamagotchi core. It derives a game tick from `clk`, ages six need levels (hunger, happiness, health, hygiene, energy, social) on that tick, and applies player commands to them. A sleep/death state machine controls which commands are accepted. The need outputs feed the status stage directly; for every need, a higher value is worse.

## Interface
- `TICK_DIV`, 50_000_000: `clk` cycles per game tick (≥2)
- `HUNGER_PER`, 4: ticks per +1 hunger
- `HAPPY_PER`, 2: ticks per +1 happiness
- `HYGIENE_PER`, 6: ticks per +1 hygiene
- `ENERGY_PER`, 5: ticks per +1 energy (awake only)
- `SOCIAL_PER`, 3: ticks per +1 social
- `clk` in 1: system clock
- `reset` in 1: asynchronous, active-low reset
- `cmd_valid` in 1: command present
- `cmd` in 3: 0 FEED, 1 PLAY, 2 CLEAN, 3 SLEEP, 4 MEDICINE, 5 PET, 6–7 reserved (accepted, no effect)
- `cmd_ready` out 1: command accepted this cycle when `cmd_valid && cmd_ready`
- `hunger`, `health`, `hygiene`, `energy`, `social` out 4 each: need levels, 0..15
- `happiness` out 5: unhappiness level, 0..31
- `asleep` out 1: state is ASLEEP
- `alive` out 1: state is not DEAD
- `tick` out 1: one-cycle pulse on the game-tick cycle

## Operation
- States:
  - AWAKE → ASLEEP on an accepted SLEEP with `energy` ≠ 0. SLEEP with `energy` = 0 is accepted with no effect.
  - ASLEEP → AWAKE on the edge where `energy` becomes 0.
  - Any state → DEAD on the edge where next `hunger` = 15.
  - DEAD is left only by reset.
- `cmd_ready` = 1 only in AWAKE. It is combinational from state.
- Tick decay: each need has a period counter that advances on `tick`. On wrap (counter = PER−1), the need increments, saturating at 15 (31 for `happiness`).
  - The energy counter holds while ASLEEP.
  - While ASLEEP, each tick decrements `energy` by 1, saturating at 0.
- Health: on each tick, if `hunger` ≥ 12 or `hygiene` ≥ 12 (pre-update values), `health` +1. Otherwise `health` is unchanged by ticks.
- Command effects (all saturate at 0 / max):
  - FEED: `hunger` −4
  - PLAY: `happiness` −6, `energy` +2
  - CLEAN: `hygiene` := 0
  - MEDICINE: `health` −4
  - PET: `social` −3, `happiness` −1
- Same-cycle tick and command: next = clamp(cur + decay_inc − cmd_dec, 0, max). Arithmetic is done one bit wider and signed before the clamp. CLEAN overrides the hygiene decay to 0.
- DEAD: all needs and period counters frozen, `tick` keeps pulsing, `cmd_ready` = 0.
- Reset values:
  - all needs 0; all period and tick counters 0
  - state AWAKE: `asleep` 0, `alive` 1, `cmd_ready` 1
  - `tick` 0

## Timing
- Tick counter counts 0..TICK_DIV−1. `tick` = 1 while count = TICK_DIV−1. Decay is applied at that cycle's closing edge.
- First `tick` after reset release occurs in cycle TICK_DIV−1, counting the first cycle as 0.
- Command latency: an accepted command's effect is visible on outputs the cycle after acceptance.
- State transitions and need updates occur on the same edge. `alive` drops in the same cycle `hunger` first reads 15.
- Reset assertion mid-operation clears everything immediately, with no clock required. Deassertion is synchronised externally.

## Structure
- Package `pet_pkg` holds:
  - command encoding constants and the state enum (AWAKE, ASLEEP, DEAD)
  - need widths (4, 5) and the threshold 12
  - a saturating add/sub function
- Sub-module `pet_need_cnt`: one need register plus its period counter.
  - parameters: WIDTH, PER
  - inputs: tick, hold, dec amount, clear
  - `pet_needs` instantiates it five times; health is separate.
- `pet_needs` holds the tick divider, FSM, command decode, and health logic.

## Test plan
Run with TICK_DIV=4 and default periods unless noted.
- Reset release, idle 16 ticks → `hunger`=4, `happiness`=8, `social`=5, `hygiene`=2, `energy`=3, `health`=0; `tick` pulses every 4 cycles.
- `hunger`=5, FEED accepted in a non-tick cycle → `hunger`=1 next cycle. Second FEED → 0, no underflow.
- `energy`=3, SLEEP → `asleep`=1, `cmd_ready`=0. PLAY held with `cmd_valid` is not accepted. After 3 ticks `energy`=0, `asleep`=0, and the held PLAY is accepted on the next cycle.
- With `hunger` forced to 14 via HUNGER_PER=1, the next tick sets `hunger`=15 and `alive`=0. Subsequent ticks and commands change nothing; reset restores all values.
- Tick and PET in the same cycle with `social` at a wrap: `social`=4 → 2 (+1 −3).
- `hygiene` ≥ 12 for 3 ticks → `health` +3. Then MEDICINE → `health` −4, clamped at 0. Mid-test async reset pulse between edges → outputs 0 immediately.
